// File: rtl/animation_pkg.sv
// Shared constants for the square animation path: FSM encoding, screen size,
// colours and the square request record.
package animation_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ERASE  = 2'd1;
  localparam logic [1:0] ST_DRAW   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOUR_RED   = 3'b100;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
  } sq_req_t;
endpackage

// File: rtl/square_scan_counter.sv
// Raster scan over a SIZE x SIZE square: col is the inner loop, row the outer.
// last flags the final pixel (SIZE-1, SIZE-1).
module square_scan_counter #(
  parameter int SIZE = 4,
  parameter int CW   = 2
) (
  input  logic          clock,
  input  logic          reset_b,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last
);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  logic [CW-1:0] col_q, col_d, row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (enable) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == LAST) && (row_q == LAST);
endmodule

// File: rtl/square_plotter.sv
// Turns one square request into a raster of single-pixel VGA writes, clipping
// off-screen pixels. SQUARE_PLOTTER_ERASE_EN adds erasing of the previous square.
module square_plotter #(
  parameter int         SIZE      = 4,
  parameter int         SCREEN_W  = animation_pkg::SCREEN_W,
  parameter int         SCREEN_H  = animation_pkg::SCREEN_H,
  parameter logic [2:0] BG_COLOUR = animation_pkg::COLOUR_BLACK
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       go,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  input  logic [2:0] in_colour,
  output logic       ready,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);
  import animation_pkg::*;

  localparam int         CW    = $clog2(SIZE);
  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);

  logic [1:0] state_q, state_d;
  sq_req_t    req_q, req_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       done_q, done_d;

  logic [CW-1:0] col, row;
  logic          last, scan_clear, scan_en;
  logic [7:0]    base_x, base_y;
  logic [2:0]    pix_colour;
  logic [8:0]    px, py;

`ifdef SQUARE_PLOTTER_ERASE_EN
  logic [7:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic       prev_valid_q, prev_valid_d;
`endif

  assign scan_clear = (state_q == ST_IDLE);
  assign scan_en    = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  square_scan_counter #(.SIZE(SIZE), .CW(CW)) u_scan (
    .clock   (clock),
    .reset_b (reset_b),
    .clear   (scan_clear),
    .enable  (scan_en),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    done_d       = 1'b0;
    base_x       = req_q.x;
    base_y       = req_q.y;
    pix_colour   = req_q.colour;
`ifdef SQUARE_PLOTTER_ERASE_EN
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_valid_d = prev_valid_q;
    if (state_q == ST_ERASE) begin
      base_x     = prev_x_q;
      base_y     = prev_y_q;
      pix_colour = BG_COLOUR;
    end
`endif
    // 9-bit sums so squares near x=255 clip instead of wrapping to the left edge
    px = {1'b0, base_x} + 9'(col);
    py = {1'b0, base_y} + 9'(row);

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          req_d = '{x: in_x, y: in_y, colour: in_colour};
`ifdef SQUARE_PLOTTER_ERASE_EN
          state_d = prev_valid_q ? ST_ERASE : ST_DRAW;
`else
          state_d = ST_DRAW;
`endif
        end
      end
      ST_ERASE, ST_DRAW: begin
        vga_x_d      = px[7:0];
        vga_y_d      = py[6:0];
        vga_colour_d = pix_colour;
        vga_plot_d   = (px < X_LIM) && (py < Y_LIM);
        if (last) state_d = (state_q == ST_DRAW) ? ST_FINISH : ST_DRAW;
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef SQUARE_PLOTTER_ERASE_EN
        prev_x_d     = req_q.x;
        prev_y_d     = req_q.y;
        prev_valid_d = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
    end
  end

`ifdef SQUARE_PLOTTER_ERASE_EN
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_valid_q <= prev_valid_d;
    end
  end
`endif

  assign ready      = (state_q == ST_IDLE);
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
endmodule
